// File: rtl/banked_mem_responder_pkg.sv
// Shared constants and types for the four-bank interleaved memory responder.
// Bank select sits just above the byte-offset bit so consecutive words hit different banks.
package banked_mem_responder_pkg;

  localparam int NUM_BANKS         = 4;
  localparam int BANK_LSB          = 1;
  localparam int BANK_MSB          = 2;
  localparam int BANK_SEL_W        = BANK_MSB - BANK_LSB + 1;
  localparam int READ_LAT          = 2;
  localparam int DEFAULT_BANK_BUSY = 4;

  typedef logic [BANK_SEL_W-1:0] bank_id_t;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_t;

endpackage

// File: rtl/banked_mem_responder_mem_bank.sv
// One word-wide memory bank: storage array, occupancy counter and first read stage.
// The bank is occupied for BANK_BUSY cycles after each accepted access, including the accept cycle.
module mem_bank
  import banked_mem_responder_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ROW_W     = 13,
  parameter int BANK_BUSY = DEFAULT_BANK_BUSY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(BANK_BUSY);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [2**ROW_W];
  bank_state_t       state;

  assign state = (cnt != '0) ? BANK_ACTIVE : BANK_IDLE;
  assign busy  = (state == BANK_ACTIVE);

  // An accept can only happen while the counter is zero, so load and decrement never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (acc) begin
      cnt <= CNT_W'(BANK_BUSY - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (acc && wr_en) begin
      mem[row] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= acc && !wr_en;
      if (acc && !wr_en) begin
        rd_data <= mem[row];
      end
    end
  end

endmodule

// File: rtl/banked_mem_responder.sv
// Memory-side responder: decodes requests onto four interleaved banks, flags illegal or
// conflicting requests, and returns read data exactly two cycles after acceptance.
module banked_mem_responder
  import banked_mem_responder_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int ROW_W     = 13,
  parameter int BANK_BUSY = DEFAULT_BANK_BUSY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 rd,
  input  logic                 wr,
  output logic [DATA_W-1:0]    data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  bank_id_t          bank;
  bank_id_t          s1_bank;
  logic [ROW_W-1:0]  row;
  logic              req;
  logic              accept;
  logic              bank_rd_valid [NUM_BANKS];
  logic [DATA_W-1:0] bank_rd_data  [NUM_BANKS];

  assign bank   = addr[BANK_MSB:BANK_LSB];
  assign row    = addr[ROW_W+2:3];
  assign req    = rd | wr;
  assign err    = req & (addr[0] | (rd & wr));
  assign stall  = req & ~err & busy[bank];
  assign accept = req & ~err & ~stall;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    mem_bank #(
      .DATA_W   (DATA_W),
      .ROW_W    (ROW_W),
      .BANK_BUSY(BANK_BUSY)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .acc     (accept && (bank == bank_id_t'(i))),
      .wr_en   (wr),
      .row     (row),
      .wdata   (data_in),
      .busy    (busy[i]),
      .rd_valid(bank_rd_valid[i]),
      .rd_data (bank_rd_data[i])
    );
  end

  // Remember which bank holds the first-stage result so the second stage can pick it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_bank <= '0;
    end else if (accept && rd) begin
      s1_bank <= bank;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      rd_valid <= bank_rd_valid[s1_bank];
      data_out <= bank_rd_valid[s1_bank] ? bank_rd_data[s1_bank] : '0;
    end
  end

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed self-checking bench for banked_mem_responder: a per-cycle vector table
// followed by hand-written bank-conflict and mid-operation reset sequences.
module tb_banked_mem_responder;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        stall;
    logic        err;
    logic        rv;
    logic [15:0] dout;
    logic [3:0]  busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int num_checks = 0;
  int num_errors = 0;

  vec_t vecs [32];

  banked_mem_responder dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .rd      (rd),
    .wr      (wr),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .stall   (stall),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic w, input logic [15:0] a,
                              input logic [15:0] d, input logic es, input logic ee,
                              input logic ev, input logic [15:0] ed, input logic [3:0] eb);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.din = d;
    v.stall = es; v.err = ee; v.rv = ev; v.dout = ed; v.busy = eb;
    return v;
  endfunction

  task automatic check_val(input string tag, input string field,
                           input logic [15:0] act, input logic [15:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s.%s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic apply_stimulus(input logic r, input logic w,
                                input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic es, input logic ee,
                              input logic ev, input logic [15:0] ed, input logic [3:0] eb);
    check_val(tag, "stall",    16'(stall),    16'(es));
    check_val(tag, "err",      16'(err),      16'(ee));
    check_val(tag, "rd_valid", 16'(rd_valid), 16'(ev));
    check_val(tag, "data_out", data_out,      ed);
    check_val(tag, "busy",     16'(busy),     16'(eb));
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 16'h0000, 4'b0000);
    vecs[1]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001);
    vecs[2]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001);
    vecs[3]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001);
    vecs[4]  = mk(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000, 4'b0000);
    vecs[5]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001);
    vecs[6]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'hBEEF, 4'b0001);
    vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0001);
    vecs[8]  = mk(0, 1, 16'h0040, 16'h1111, 0, 0, 0, 16'h0000, 4'b0000);
    vecs[9]  = mk(0, 1, 16'h0042, 16'h2222, 0, 0, 0, 16'h0000, 4'b0001);
    vecs[10] = mk(0, 1, 16'h0044, 16'h3333, 0, 0, 0, 16'h0000, 4'b0011);
    vecs[11] = mk(0, 1, 16'h0046, 16'h4444, 0, 0, 0, 16'h0000, 4'b0111);
    vecs[12] = mk(1, 0, 16'h0040, 16'h0000, 0, 0, 0, 16'h0000, 4'b1110);
    vecs[13] = mk(1, 0, 16'h0042, 16'h0000, 0, 0, 0, 16'h0000, 4'b1101);
    vecs[14] = mk(1, 0, 16'h0044, 16'h0000, 0, 0, 1, 16'h1111, 4'b1011);
    vecs[15] = mk(1, 0, 16'h0046, 16'h0000, 0, 0, 1, 16'h2222, 4'b0111);
    vecs[16] = mk(1, 0, 16'h0041, 16'h0000, 0, 1, 1, 16'h3333, 4'b1110);
    vecs[17] = mk(1, 1, 16'h0040, 16'h9999, 0, 1, 1, 16'h4444, 4'b1100);
    vecs[18] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b1000);
    vecs[19] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0000);
    vecs[20] = mk(0, 1, 16'h0080, 16'hA0A0, 0, 0, 0, 16'h0000, 4'b0000);
    vecs[21] = mk(0, 1, 16'h0082, 16'hB1B1, 0, 0, 0, 16'h0000, 4'b0001);
    vecs[22] = mk(0, 1, 16'h0084, 16'hC2C2, 0, 0, 0, 16'h0000, 4'b0011);
    vecs[23] = mk(0, 1, 16'h0086, 16'hD3D3, 0, 0, 0, 16'h0000, 4'b0111);
    vecs[24] = mk(1, 0, 16'h0080, 16'h0000, 0, 0, 0, 16'h0000, 4'b1110);
    vecs[25] = mk(1, 0, 16'h0082, 16'h0000, 0, 0, 0, 16'h0000, 4'b1101);
    vecs[26] = mk(1, 0, 16'h0084, 16'h0000, 0, 0, 1, 16'hA0A0, 4'b1011);
    vecs[27] = mk(1, 0, 16'h0086, 16'h0000, 0, 0, 1, 16'hB1B1, 4'b0111);
    vecs[28] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'hC2C2, 4'b1110);
    vecs[29] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'hD3D3, 4'b1100);
    vecs[30] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b1000);
    vecs[31] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0000);

    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset", 0, 0, 0, 16'h0000, 4'b0000);
    rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
      check_output($sformatf("vec%0d", i), vecs[i].stall, vecs[i].err,
                   vecs[i].rv, vecs[i].dout, vecs[i].busy);
    end

    // Same-bank conflict: 0x0048 is stalled behind 0x0040 until bank 0 frees up.
    apply_stimulus(0, 1, 16'h0048, 16'h5A5A);
    check_output("conf_wr", 0, 0, 0, 16'h0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 16'h0000, 16'h0000);
      check_output($sformatf("conf_idle%0d", i), 0, 0, 0, 16'h0000, 4'b0001);
    end
    apply_stimulus(1, 0, 16'h0040, 16'h0000);
    check_output("conf_n", 0, 0, 0, 16'h0000, 4'b0000);
    apply_stimulus(1, 0, 16'h0048, 16'h0000);
    check_output("conf_n1", 1, 0, 0, 16'h0000, 4'b0001);
    apply_stimulus(1, 0, 16'h0048, 16'h0000);
    check_output("conf_n2", 1, 0, 1, 16'h1111, 4'b0001);
    apply_stimulus(1, 0, 16'h0048, 16'h0000);
    check_output("conf_n3", 1, 0, 0, 16'h0000, 4'b0001);
    apply_stimulus(1, 0, 16'h0048, 16'h0000);
    check_output("conf_n4", 0, 0, 0, 16'h0000, 4'b0000);
    apply_stimulus(0, 0, 16'h0000, 16'h0000);
    check_output("conf_n5", 0, 0, 0, 16'h0000, 4'b0001);
    apply_stimulus(0, 0, 16'h0000, 16'h0000);
    check_output("conf_n6", 0, 0, 1, 16'h5A5A, 4'b0001);
    apply_stimulus(0, 0, 16'h0000, 16'h0000);
    check_output("conf_n7", 0, 0, 0, 16'h0000, 4'b0001);
    apply_stimulus(0, 0, 16'h0000, 16'h0000);
    check_output("conf_n8", 0, 0, 0, 16'h0000, 4'b0000);

    // Reset while a read is in flight: the read is dropped, the written word survives.
    apply_stimulus(0, 1, 16'h0020, 16'h7777);
    check_output("rst_wr", 0, 0, 0, 16'h0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 16'h0000, 16'h0000);
      check_output($sformatf("rst_idle%0d", i), 0, 0, 0, 16'h0000, 4'b0001);
    end
    apply_stimulus(1, 0, 16'h0020, 16'h0000);
    check_output("rst_n", 0, 0, 0, 16'h0000, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0;
    @(negedge clk);
    check_output("rst_n1", 0, 0, 0, 16'h0000, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_n2", 0, 0, 0, 16'h0000, 4'b0000);
    apply_stimulus(0, 0, 16'h0000, 16'h0000);
    check_output("rst_n3", 0, 0, 0, 16'h0000, 4'b0000);
    apply_stimulus(1, 0, 16'h0020, 16'h0000);
    check_output("rst_reread", 0, 0, 0, 16'h0000, 4'b0000);
    apply_stimulus(0, 0, 16'h0000, 16'h0000);
    check_output("rst_reread1", 0, 0, 0, 16'h0000, 4'b0001);
    apply_stimulus(0, 0, 16'h0000, 16'h0000);
    check_output("rst_reread2", 0, 0, 1, 16'h7777, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
